// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter shared between a CPU, a DMA engine and a
// loader that can park the CPU.
//
// The CPU normally wins. A DMA request that has been denied STARVE_MAX cycles in
// a row takes the next slot, even over the CPU. In HOLD the CPU is never
// granted and only DMA reaches the RAM. The RAM is synchronous, so read data
// comes back one cycle after the address. That data is steered to whichever
// requester issued the read.
//
// Ports
//   clk, reset                       clock; asynchronous active-low reset
//   cpu_valid/addr/we/wdata          CPU access request (one per cycle)
//   cpu_rdata, cpu_rdy               CPU read data (held), 0 = CPU stalled
//   dma_req/addr/we/wdata            DMA request, held stable until dma_ack
//   dma_ack, dma_rdata, dma_rvalid   grant strobe, read data, read-data valid
//   hold_req, hold_ack               loader ownership request / CPU parked
//   ram_addr/we/wdata, ram_rdata     synchronous single-port RAM interface
module mem_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rdy,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_we,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic              dma_rvalid,
    input  logic              hold_req,
    output logic              hold_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic       live;      // set by the first clock edge that sees reset released
    logic [3:0] starve;
    logic       rd_cpu;    // RAM read data in this cycle belongs to the CPU
    logic       rd_dma;    // RAM read data in this cycle belongs to the DMA
    logic [7:0] cpu_last;
    logic [7:0] dma_last;
    logic       cpu_gnt;
    logic       dma_gnt;

    // Grants are gated by live. No access can start while reset is asserted,
    // and none starts before an edge has sampled reset released.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (live) begin
            if (state == RUN && cpu_valid && starve < STARVE_LIM)
                cpu_gnt = 1'b1;
            else if (dma_req)
                dma_gnt = 1'b1;
        end
    end

    assign ram_addr   = dma_gnt ? dma_addr  : cpu_addr;
    assign ram_wdata  = dma_gnt ? dma_wdata : cpu_wdata;
    assign ram_we     = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);

    // While reset is low the CPU is not stalled.
    assign cpu_rdy    = ~reset | ~cpu_valid | cpu_gnt;
    assign dma_ack    = dma_gnt;
    assign hold_ack   = (state == HOLD);
    assign dma_rvalid = rd_dma;

    // The RAM returns data in the cycle after the address. The owner sees it
    // directly in that cycle, and afterwards the captured copy is held.
    assign cpu_rdata  = rd_cpu ? ram_rdata : cpu_last;
    assign dma_rdata  = rd_dma ? ram_rdata : dma_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            live     <= 1'b0;
            starve   <= 4'd0;
            rd_cpu   <= 1'b0;
            rd_dma   <= 1'b0;
            cpu_last <= 8'h00;
            dma_last <= 8'h00;
        end else begin
            live <= 1'b1;

            case (state)
                RUN:     if (hold_req)  state <= HOLD;
                HOLD:    if (!hold_req) state <= RUN;
                default: state <= RUN;
            endcase

            if (!dma_req || dma_gnt)
                starve <= 4'd0;
            else if (starve < STARVE_LIM)
                starve <= starve + 4'd1;

            rd_cpu <= cpu_gnt & ~cpu_we;
            rd_dma <= dma_gnt & ~dma_we;
            if (rd_cpu) cpu_last <= ram_rdata;
            if (rd_dma) dma_last <= ram_rdata;
        end
    end

endmodule
